uart_hex_word_parser: RTL and testbench
=======================================

# uart_hex_word_parser

Downstream consumer of the ASCII-to-hex decoder in the UART controller receive path. Takes received bytes from the UART receiver and accumulates hex digits, most significant first, into a word. A line terminator (CR/LF) completes the word, which is presented to the command logic over a valid/ready handshake. Malformed lines are flagged and discarded up to the next terminator.

## Interface
Parameters:
- NIBBLES, 4, maximum hex digits per word; legal range 1..8; word width = 4*NIBBLES.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_DATA  in  8  received byte; sampled only when RX_VALID is high.
- RX_VALID  in  1  one-cycle strobe marking a new byte.
- WORD  out  4*NIBBLES  assembled word, right-aligned, zero-extended.
- WORD_VALID  out  1  WORD is valid; held until accepted.
- WORD_READY  in  1  consumer accepts WORD when high with WORD_VALID.
- DIGITS  out  4  number of digits in the current or presented word.
- ERR  out  1  one-cycle pulse: invalid character or digit overflow.
- DROP  out  1  one-cycle pulse: byte discarded because a word is pending.

## Operation
- Reset values: state IDLE; accumulator, WORD, DIGITS, WORD_VALID, ERR and DROP all 0.
- Each byte is classified by the decoder sub-module into hex digit (0-9, A-F, a-f) or non-hex. Terminator = 0x0D or 0x0A. Space = 0x20.
- IDLE:
  - hex digit → acc = nibble, count = 1, go to COLLECT.
  - terminator or space → ignored; empty lines produce no word.
  - other → ERR, go to SKIP.
- COLLECT:
  - hex digit with count < NIBBLES → acc = {acc[4*NIBBLES-5:0], nib}, count+1.
  - hex digit with count == NIBBLES → ERR, go to SKIP.
  - space → ignored.
  - terminator → WORD = acc, WORD_VALID = 1, go to HOLD.
  - other → ERR, go to SKIP.
- SKIP: discards every byte until a terminator, then clears acc/count and goes to IDLE. No ERR is raised for further bytes.
- HOLD: WORD, DIGITS and WORD_VALID are stable.
  - WORD_READY high at an edge → WORD_VALID = 0, acc/count cleared, go to IDLE.
  - Any RX_VALID byte in HOLD, including in the same cycle as WORD_READY, is dropped and pulses DROP.
- DIGITS tracks count in COLLECT and HOLD, and is 0 in IDLE and SKIP.
- ERR and DROP are never both asserted; each lasts exactly one cycle per offending byte.
- RST at any time, including mid-line or in HOLD, returns all state and outputs to reset values on assertion. No partial word is emitted.

## Timing
- Byte processing: one byte per cycle; back-to-back RX_VALID is supported in every state.
- Terminator accepted at edge N → WORD_VALID visible from edge N (registered output), i.e. one cycle after the strobe.
- ERR/DROP rise at the edge that samples the offending byte and fall at the next edge.
- Handshake: a transfer occurs at the edge where WORD_VALID & WORD_READY. WORD_READY while WORD_VALID is low has no effect.
- Minimum line-to-word throughput: a new word can be presented 2 cycles after acceptance, via "digit, terminator".

## Configuration
- HEX_PARSER_BKSP_EN defined:
  - In COLLECT, 0x08 or 0x7F → acc = acc >> 4, count-1. If count reaches 0, go to IDLE.
  - In IDLE, 0x08/0x7F is ignored. In SKIP, it is discarded.
- Not defined: 0x08/0x7F is a non-hex character (ERR, SKIP).

## Structure
- Shared package/header `uart_pkg`:
  - character constants: CR, LF, SPACE, BS, DEL.
  - state encodings: IDLE, COLLECT, SKIP, HOLD.
- Sub-module: one instance of the existing combinational ASCII-to-hex decoder (VS_DC_ASCII_HEX), driven by RX_DATA. Its HEX/HEX_FLG outputs supply the nibble and the digit flag.
- Remaining logic (FSM, accumulator, counter, handshake registers) lives in this module.

## Test plan
- NIBBLES=4, send "1A3F\r" at back-to-back strobes, WORD_READY low → WORD=16'h1A3F, DIGITS=4, WORD_VALID from edge after CR and held 10 cycles; then WORD_READY=1 → WORD_VALID=0 next edge.
- Send "7\r", then "ff\n" and " 2 b\r" → 16'h0007 (DIGITS=1), 16'h00FF (DIGITS=2), 16'h002B; no ERR.
- Send "12G4\r" → ERR one cycle after 'G', no WORD_VALID; then "5\r" → 16'h0005. Separately, "12345\r" → ERR on '5', no word.
- In HOLD with WORD=16'h00AB, send '9' with WORD_READY=0, then '8' in the same cycle WORD_READY=1 → two DROP pulses, WORD unchanged until accepted, state IDLE after; "3\r" → 16'h0003.
- HEX_PARSER_BKSP_EN defined: "12\x083\r" → 16'h0013; "1\x08\r" → no word, no ERR. Without the macro: the same stimulus gives ERR at 0x08 and no word.
- Assert RST after "AB" and again during HOLD → all outputs 0 immediately; subsequent "C\r" → 16'h000C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive-path constants: control characters and parser state encoding.
package uart_pkg;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] DEL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SKIP    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic logic is_term(input logic [7:0] c);
    return (c == CR) || (c == LF);
  endfunction

endpackage

// File: rtl/vs_dc_ascii_hex.sv
// Combinational ASCII-to-hex decoder: HEX_FLG marks 0-9/A-F/a-f, HEX carries the nibble (0 otherwise).
module VS_DC_ASCII_HEX (
  input  logic [7:0] ASCII,
  output logic [3:0] HEX,
  output logic       HEX_FLG
);

  always_comb begin
    HEX     = 4'h0;
    HEX_FLG = 1'b0;
    if (ASCII >= 8'h30 && ASCII <= 8'h39) begin
      HEX     = 4'(ASCII - 8'h30);
      HEX_FLG = 1'b1;
    end else if (ASCII >= 8'h41 && ASCII <= 8'h46) begin
      HEX     = 4'(ASCII - 8'h37);
      HEX_FLG = 1'b1;
    end else if (ASCII >= 8'h61 && ASCII <= 8'h66) begin
      HEX     = 4'(ASCII - 8'h57);
      HEX_FLG = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_word_parser.sv
// Accumulates MSB-first hex digits into a word, emitted on CR/LF over valid/ready.
// Optional backspace/delete editing enabled by defining HEX_PARSER_BKSP_EN.
module uart_hex_word_parser
  import uart_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           RX_DATA,
  input  logic                 RX_VALID,
  output logic [4*NIBBLES-1:0] WORD,
  output logic                 WORD_VALID,
  input  logic                 WORD_READY,
  output logic [3:0]           DIGITS,
  output logic                 ERR,
  output logic                 DROP
);

  localparam int W = 4 * NIBBLES;

  state_t         state, state_n;
  logic [W-1:0]   acc, acc_n, word_n;
  logic [3:0]     cnt, cnt_n;
  logic           wv_n, err_n, drop_n;
  logic [3:0]     nib;
  logic           is_hex, term, space;

  VS_DC_ASCII_HEX u_dec (
    .ASCII   (RX_DATA),
    .HEX     (nib),
    .HEX_FLG (is_hex)
  );

  assign term  = is_term(RX_DATA);
  assign space = (RX_DATA == SPACE);

`ifdef HEX_PARSER_BKSP_EN
  logic bksp;
  assign bksp = (RX_DATA == BS) || (RX_DATA == DEL);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
      ERR        <= 1'b0;
      DROP       <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      WORD       <= word_n;
      WORD_VALID <= wv_n;
      ERR        <= err_n;
      DROP       <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    word_n  = WORD;
    wv_n    = WORD_VALID;
    err_n   = 1'b0;
    drop_n  = 1'b0;
    case (state)
      IDLE: if (RX_VALID) begin
        if (is_hex) begin
          acc_n   = W'(nib);
          cnt_n   = 4'd1;
          state_n = COLLECT;
        end else if (term || space) begin
          // blank lines and padding are silently ignored
        end
`ifdef HEX_PARSER_BKSP_EN
        else if (bksp) begin
        end
`endif
        else begin
          err_n   = 1'b1;
          state_n = SKIP;
        end
      end
      COLLECT: if (RX_VALID) begin
        if (is_hex) begin
          if (cnt < 4'(NIBBLES)) begin
            acc_n = W'({acc, nib});
            cnt_n = cnt + 4'd1;
          end else begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end else if (space) begin
        end else if (term) begin
          word_n  = acc;
          wv_n    = 1'b1;
          state_n = HOLD;
        end
`ifdef HEX_PARSER_BKSP_EN
        else if (bksp) begin
          acc_n = acc >> 4;
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) state_n = IDLE;
        end
`endif
        else begin
          err_n   = 1'b1;
          state_n = SKIP;
        end
      end
      SKIP: if (RX_VALID && term) begin
        acc_n   = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end
      HOLD: begin
        // bytes arriving while a word is pending are lost, even on the accept edge
        drop_n = RX_VALID;
        if (WORD_READY) begin
          wv_n    = 1'b0;
          acc_n   = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign DIGITS = (state == COLLECT || state == HOLD) ? cnt : 4'd0;

endmodule

// File: tb/tb_uart_hex_word_parser.sv
// Directed bench for uart_hex_word_parser (NIBBLES=4); follows HEX_PARSER_BKSP_EN if defined.
module tb_uart_hex_word_parser;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = 8'h00;
  logic        RX_VALID = 1'b0;
  logic [15:0] WORD;
  logic        WORD_VALID;
  logic        WORD_READY = 1'b0;
  logic [3:0]  DIGITS;
  logic        ERR, DROP;

  int n_chk = 0, n_fail = 0;
  int err_cnt = 0, drop_cnt = 0, both_cnt = 0;
  int e0, d0;

  uart_hex_word_parser #(.NIBBLES(4)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .WORD(WORD), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .DIGITS(DIGITS), .ERR(ERR), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ERR) err_cnt++;
    if (DROP) drop_cnt++;
    if (ERR && DROP) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the byte was sampled
  task automatic put(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    RX_VALID = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
    idle(1);
  endtask

  task automatic expect_word(input string tag, input logic [15:0] w, input logic [3:0] d);
    chk({tag, "_vld"}, WORD_VALID, 1'b1);
    chk({tag, "_word"}, WORD, w);
    chk({tag, "_dig"}, DIGITS, d);
    WORD_READY = 1'b1;
    @(negedge CLK);
    WORD_READY = 1'b0;
    chk({tag, "_acc"}, WORD_VALID, 1'b0);
  endtask

  initial begin
    int held;
    @(negedge CLK);
    chk("rst_word", WORD, 16'h0);
    chk("rst_vld", WORD_VALID, 1'b0);
    chk("rst_dig", DIGITS, 4'd0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_drop", DROP, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // back-to-back line, word held while consumer stalls
    put("1"); put("A"); put("3"); put("F"); put(8'h0D);
    chk("t1_vld_edge", WORD_VALID, 1'b1);
    RX_VALID = 1'b0;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (WORD_VALID === 1'b1 && WORD === 16'h1A3F) held++;
    end
    chk("t1_held", held, 10);
    expect_word("t1", 16'h1A3F, 4'd4);
    chk("t1_idle_dig", DIGITS, 4'd0);

    e0 = err_cnt;
    send_str("7\r");    expect_word("t2a", 16'h0007, 4'd1);
    send_str("ff\n");   expect_word("t2b", 16'h00FF, 4'd2);
    send_str(" 2 b\r"); expect_word("t2c", 16'h002B, 4'd2);
    send_str("\r\n");
    chk("t2_empty_novld", WORD_VALID, 1'b0);
    chk("t2_noerr", err_cnt - e0, 0);

    // invalid character mid-line
    e0 = err_cnt;
    put("1"); put("2"); put("G");
    chk("t3_err_pulse", ERR, 1'b1);
    put("4");
    chk("t3_err_fall", ERR, 1'b0);
    put(8'h0D); idle(1);
    chk("t3_noword", WORD_VALID, 1'b0);
    chk("t3_one_err", err_cnt - e0, 1);
    send_str("5\r");    expect_word("t3b", 16'h0005, 4'd1);
    // digit overflow
    e0 = err_cnt;
    put("1"); put("2"); put("3"); put("4");
    chk("t3_full_dig", DIGITS, 4'd4);
    put("5");
    chk("t3_ovf_err", ERR, 1'b1);
    put(8'h0D); idle(1);
    chk("t3_ovf_noword", WORD_VALID, 1'b0);
    chk("t3_ovf_one_err", err_cnt - e0, 1);

    // drops while holding, including on the accept edge
    send_str("ab\r");
    d0 = drop_cnt;
    put("9");
    chk("t4_drop1", DROP, 1'b1);
    chk("t4_word_kept", WORD, 16'h00AB);
    chk("t4_vld_kept", WORD_VALID, 1'b1);
    WORD_READY = 1'b1;
    put("8");
    WORD_READY = 1'b0;
    chk("t4_drop2", DROP, 1'b1);
    chk("t4_accepted", WORD_VALID, 1'b0);
    idle(1);
    chk("t4_drop_fall", DROP, 1'b0);
    chk("t4_drop_cnt", drop_cnt - d0, 2);
    chk("t4_idle_dig", DIGITS, 4'd0);
    send_str("3\r");    expect_word("t4b", 16'h0003, 4'd1);

    // backspace editing
    e0 = err_cnt;
    put("1"); put("2"); put(8'h08);
`ifdef HEX_PARSER_BKSP_EN
    chk("t5_bs_noerr", ERR, 1'b0);
    chk("t5_bs_dig", DIGITS, 4'd1);
    put("3"); put(8'h0D); idle(1);
    expect_word("t5", 16'h0013, 4'd2);
    put("1"); put(8'h7F); put(8'h0D); idle(1);
    chk("t5_empty_novld", WORD_VALID, 1'b0);
    chk("t5_noerr", err_cnt - e0, 0);
`else
    chk("t5_bs_err", ERR, 1'b1);
    put("3"); put(8'h0D); idle(1);
    chk("t5_noword", WORD_VALID, 1'b0);
    put("1"); put(8'h08);
    chk("t5_bs_err2", ERR, 1'b1);
    put(8'h0D); idle(1);
    chk("t5_noword2", WORD_VALID, 1'b0);
    chk("t5_err_cnt", err_cnt - e0, 2);
`endif

    // asynchronous reset mid-line and in HOLD
    put("A"); put("B"); idle(1);
    chk("t6_mid_dig", DIGITS, 4'd2);
    RST = 1'b1;
    #1;
    chk("t6_rst_dig", DIGITS, 4'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    send_str("\r");
    chk("t6_partial_novld", WORD_VALID, 1'b0);
    send_str("cd\r");
    chk("t6_hold_vld", WORD_VALID, 1'b1);
    RST = 1'b1;
    #1;
    chk("t6_rst_vld", WORD_VALID, 1'b0);
    chk("t6_rst_word", WORD, 16'h0);
    chk("t6_rst_dig2", DIGITS, 4'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    send_str("C\r");    expect_word("t6", 16'h000C, 4'd1);

    chk("err_drop_excl", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
